eth_pkt_arbiter: RTL and testbench
==================================

Name: eth_pkt_arbiter

Overview:
- Packet-granular round-robin arbiter for one egress port of eth_sw.
- Inputs are the heads of the per-ingress-port packet queues: 34-bit words, data plus SOP/EOP flags.
- Grants one requester at a time and holds the grant from SOP through EOP, so packets never interleave on the egress port.
- Drives the registered egress word stream, applies back-pressure via out_ready, drops orphan words and aborts runaway packets.

Parameters:
NUM_REQ, 2, number of requesting ingress queues (2..8)
DATA_W, 32, payload width per word
MAX_PKT_WORDS, 64, watchdog limit of words per packet including SOP and EOP words (>=2)

Ports:
clk  in  1  clock
resetN  in  1  reset
req_valid  in  NUM_REQ  bit i: queue i head word valid
req_data  in  NUM_REQ*(DATA_W+2)  flattened head words; slice i = [i*(DATA_W+2) +: DATA_W+2]; bit DATA_W = SOP, bit DATA_W+1 = EOP
req_pop  out  NUM_REQ  combinational; bit i pops queue i head this cycle
out_ready  in  1  egress can accept a word
out_valid  out  1  registered egress word valid
out_data  out  DATA_W  registered egress payload
out_sop  out  1  registered SOP flag
out_eop  out  1  registered EOP flag
grant_id  out  $clog2(NUM_REQ)  current or last granted requester
busy  out  1  high in state XFER
err_abort  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Clock and reset: reset resetN, asynchronous, active-low; clock clk.
- Reset values: out_valid=0, out_data=0, out_sop=0, out_eop=0, grant_id=0, busy=0, err_abort=0, state=IDLE, word_cnt=0. The rr pointer is NUM_REQ-1, so requester 0 wins first. req_pop=0 while resetN is low.
- States:
  - IDLE: arbitrate.
  - XFER: stream the granted packet.
- IDLE, candidate selection:
  - A candidate is any i with req_valid[i]=1 and SOP=1.
  - Pick the first candidate searching from rr+1 upward, with modulo-NUM_REQ wrap.
  - On a pick: grant_id<=i, busy<=1, go to XFER next cycle. No pop occurs in the arbitration cycle, so arbitration costs one cycle.
- IDLE, orphan drop:
  - Any i with req_valid[i]=1 and SOP=0 has no packet context.
  - Assert req_pop[i] the same cycle to drop it. No egress word is produced.
  - All orphan queues drop in parallel; arbitration continues in that same cycle among the SOP heads.
- XFER, word transfer:
  - A word transfers on a cycle with req_valid[g]=1 and out_ready=1, where g=grant_id. req_pop[g]=1 that cycle.
  - On the next edge: out_valid<=1 and out_data/out_sop/out_eop are loaded from the head word. Latency is one cycle.
  - Otherwise out_valid<=0 on the next edge. Other bits of req_pop stay 0.
  - An empty queue head mid-packet (req_valid[g]=0) stalls without error.
- XFER, packet end:
  - word_cnt increments per transferred word.
  - A transferred word with EOP=1 ends the packet: rr<=g, word_cnt<=0, busy<=0, back to IDLE.
  - A word carrying both SOP and EOP is a complete one-word packet.
- XFER, SOP within a packet: a transferred word with SOP=1 other than the first word is forwarded with out_sop forced to 0.
- Watchdog abort:
  - Triggers when word_cnt reaches MAX_PKT_WORDS with no EOP seen.
  - The MAX_PKT_WORDS-th transferred word is emitted with out_eop forced to 1.
  - err_abort pulses on that same output cycle; rr<=g; return to IDLE.
  - The remaining words of that packet are later dropped as orphans in IDLE.
- Fairness: the winner has lowest priority in the next arbitration, giving strict alternation under continuous load.
- Reset mid-packet: all state and outputs return to reset values immediately. Partial packets are not completed.
- out_ready low: no pop, out_valid<=0 next cycle, grant held.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined: adds outputs pkt_count[15:0] and drop_count[15:0], both reset to 0 and wrapping on overflow.
  - pkt_count increments on each emitted out_eop, including aborts.
  - drop_count increments once per cycle in which at least one orphan pop occurs.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Single packet: req0 presents SOP 0x0000BEEF, 0x11, then EOP 0x22, out_ready=1 -> out_valid words 0xBEEF(sop), 0x11, 0x22(eop) on consecutive cycles; the first word appears 2 cycles after req_valid rises; busy drops after the EOP cycle.
- Contention: both requesters continuously hold 3-word packets -> egress order req0, req1, req0, req1; no interleaving inside a packet; grant_id toggles 0,1,0,1.
- Back-pressure: toggle out_ready 1,0,1,0 during a 4-word packet -> req_pop and out_valid follow out_ready with 1-cycle lag; no word is lost or duplicated.
- Orphan drop: req1 head = non-SOP 0x55 while IDLE -> req_pop[1] asserts the same cycle, no egress word; with ARB_STATS_EN, drop_count=1.
- Watchdog: MAX_PKT_WORDS=4, req0 sends 6 words without EOP -> 4th word emitted with out_eop=1 and err_abort pulses; words 5-6 are dropped; a following valid packet passes intact.
- Async reset asserted mid-XFER -> all outputs 0 immediately; after release, req0 wins the first arbitration.

Source files
------------

// File: rtl/eth_pkt_arbiter.sv
// eth_pkt_arbiter: packet-granular round-robin arbiter for one egress port.
// Define ARB_STATS_EN to add the pkt_count/drop_count statistics outputs.
module eth_pkt_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int DATA_W        = 32,
  parameter int MAX_PKT_WORDS = 64
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*(DATA_W+2)-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_pop,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [DATA_W-1:0]              out_data,
  output logic                           out_sop,
  output logic                           out_eop,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy,
  output logic                           err_abort
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]                    pkt_count,
  output logic [15:0]                    drop_count
`endif
);

  localparam int WW = DATA_W + 2;
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_PKT_WORDS + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t            state, state_nx;
  logic [IW-1:0]     rr;
  logic [CW-1:0]     word_cnt;
  logic [WW-1:0]     head [NUM_REQ];
  logic [NUM_REQ-1:0] cand, orph, pop_c;
  logic              pick_vld;
  logic [IW-1:0]     pick_idx, idx;
  logic [WW-1:0]     gw;
  logic              cnt_last, xfer, last, abort;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      head[i] = req_data[i*WW +: WW];
      cand[i] = req_valid[i] & head[i][DATA_W];
      orph[i] = req_valid[i] & ~head[i][DATA_W];
    end
  end

  // search starts just past the last winner, so it has lowest priority
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(rr) + k) % NUM_REQ);
      if (!pick_vld && cand[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx;
      end
    end
  end

  assign gw       = head[grant_id];
  assign cnt_last = (word_cnt == CW'(MAX_PKT_WORDS - 1));

  always_comb begin
    state_nx = state;
    pop_c    = '0;
    xfer     = 1'b0;
    last     = 1'b0;
    abort    = 1'b0;
    unique case (state)
      IDLE: begin
        pop_c = orph;
        if (pick_vld) state_nx = XFER;
      end
      XFER: begin
        xfer            = req_valid[grant_id] & out_ready;
        pop_c[grant_id] = xfer;
        last            = xfer & (gw[DATA_W+1] | cnt_last);
        abort           = xfer & ~gw[DATA_W+1] & cnt_last;
        if (last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign req_pop = pop_c & {NUM_REQ{resetN}};
  assign busy    = (state == XFER);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      rr        <= IW'(NUM_REQ - 1);
      grant_id  <= '0;
      word_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      err_abort <= 1'b0;
    end else begin
      state     <= state_nx;
      out_valid <= xfer;
      err_abort <= abort;
      if (state == IDLE && pick_vld) grant_id <= pick_idx;
      if (xfer) begin
        out_data <= gw[DATA_W-1:0];
        out_sop  <= gw[DATA_W] & (word_cnt == '0);
        out_eop  <= gw[DATA_W+1] | cnt_last;
        word_cnt <= last ? '0 : word_cnt + CW'(1);
      end
      if (last) rr <= grant_id;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      if (last) pkt_count <= pkt_count + 16'd1;
      if (state == IDLE && |orph) drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eth_pkt_arbiter.sv
// tb_eth_pkt_arbiter: vector table, directed corner sequences and
// randomized traffic against a packet-level round-robin model.
module tb_eth_pkt_arbiter;
  localparam int NR = 3;
  localparam int DW = 32;
  localparam int MX = 4;
  localparam int WW = DW + 2;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              resetN;
  logic [NR-1:0]     req_valid, req_pop;
  logic [NR*WW-1:0]  req_data;
  logic              out_ready, out_valid, out_sop, out_eop;
  logic [DW-1:0]     out_data;
  logic [IW-1:0]     grant_id;
  logic              busy, err_abort;
`ifdef ARB_STATS_EN
  logic [15:0]       pkt_count, drop_count;
`endif

  always #5 clk = ~clk;

  eth_pkt_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_PKT_WORDS(MX)) dut (
    .clk(clk), .resetN(resetN),
    .req_valid(req_valid), .req_data(req_data), .req_pop(req_pop),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .grant_id(grant_id),
    .busy(busy), .err_abort(err_abort)
`ifdef ARB_STATS_EN
    , .pkt_count(pkt_count), .drop_count(drop_count)
`endif
  );

  typedef struct packed {
    logic [NR-1:0] v;
    logic [WW-1:0] d0;
    logic [WW-1:0] d1;
    logic          rdy;
    logic [NR-1:0] pop;
    logic          ov;
    logic [DW-1:0] od;
    logic          s;
    logic          e;
    logic          b;
  } vec_t;

  int n_pass = 0, n_tot = 0;
  int err_n = 0, err_eop_n = 0;
  logic [WW-1:0] dq [NR][$];
  logic [WW-1:0] mw [NR][$];
  int            ml [NR][$];
  logic [WW-1:0] rx[$], ex[$];
  logic [IW-1:0] gq[$];
  int            eg[$];
  bit            use_q = 0, rnd_rdy = 0;
  logic [NR-1:0] pop_s;
  vec_t          tv [8];

  always @(negedge clk) begin
    if (resetN === 1'b1) begin
      if (out_valid) begin
        rx.push_back({out_eop, out_sop, out_data});
        if (out_sop) gq.push_back(grant_id);
      end
      if (err_abort) begin
        err_n++;
        if (out_valid && out_eop) err_eop_n++;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic [NR-1:0] v, input logic [WW-1:0] d0,
                              input logic [WW-1:0] d1, input logic rdy,
                              input logic [NR-1:0] pop, input logic ov,
                              input logic [DW-1:0] od, input logic s,
                              input logic e, input logic b);
    vec_t r;
    r.v = v; r.d0 = d0; r.d1 = d1; r.rdy = rdy; r.pop = pop;
    r.ov = ov; r.od = od; r.s = s; r.e = e; r.b = b;
    return r;
  endfunction

  task automatic drive_q();
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < NR; i++)
      if (dq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[i*WW +: WW] = dq[i][0];
      end
  endtask

  task automatic tick();
    @(negedge clk);
    pop_s = req_pop;
    @(posedge clk);
    #1;
    if (use_q) begin
      for (int i = 0; i < NR; i++)
        if (pop_s[i] && dq[i].size() > 0) dq[i].delete(0);
      if (rnd_rdy) out_ready = 1'($urandom);
      drive_q();
    end
  endtask

  task automatic add_pkt(input int q, input int len, input bit emb);
    logic [WW-1:0] w;
    for (int k = 0; k < len; k++) begin
      w[DW-1:0] = $urandom;
      w[DW]     = (k == 0) ? 1'b1 : (emb ? ($urandom_range(0, 2) == 0) : 1'b0);
      w[DW+1]   = (k == len - 1);
      dq[q].push_back(w);
      mw[q].push_back(w);
    end
    ml[q].push_back(len);
  endtask

  // packet-level round robin over whole queued packets
  task automatic model(input int start, output int last_rr);
    int p, len;
    bit any;
    logic [WW-1:0] w;
    ex.delete();
    eg.delete();
    p = start;
    do begin
      any = 0;
      for (int k = 1; k <= NR; k++) begin
        int i;
        i = (p + k) % NR;
        if (!any && ml[i].size() > 0) begin
          len = ml[i].pop_front();
          for (int j = 0; j < len; j++) begin
            w = mw[i].pop_front();
            w[DW] = (j == 0);
            ex.push_back(w);
          end
          eg.push_back(i);
          p = i;
          any = 1;
        end
      end
    end while (any);
    last_rr = p;
  endtask

  task automatic run_q(input string nm, input int budget);
    for (int c = 0; c < budget && rx.size() < ex.size(); c++) tick();
    chk({nm, "_count"}, 64'(rx.size()), 64'(ex.size()));
    for (int i = 0; i < ex.size() && i < rx.size(); i++)
      chk($sformatf("%s_w%0d", nm, i), 64'(rx[i]), 64'(ex[i]));
    chk({nm, "_npkt"}, 64'(gq.size()), 64'(eg.size()));
    for (int i = 0; i < eg.size() && i < gq.size(); i++)
      chk($sformatf("%s_g%0d", nm, i), 64'(gq[i]), 64'(eg[i]));
  endtask

  initial begin
    int rr_m, e0, left;
    logic [NR-1:0] p;
    bit exp_pop, prev_pop;

    tv[0] = mk(3'b001, {2'b01, 32'h0000BEEF}, '0, 1, 3'b000, 0, 0, 0, 0, 0);
    tv[1] = mk(3'b001, {2'b01, 32'h0000BEEF}, '0, 1, 3'b001, 0, 0, 0, 0, 1);
    tv[2] = mk(3'b001, {2'b00, 32'h00000011}, '0, 1, 3'b001, 1, 32'hBEEF, 1, 0, 1);
    tv[3] = mk(3'b001, {2'b10, 32'h00000022}, '0, 1, 3'b001, 1, 32'h11, 0, 0, 1);
    tv[4] = mk(3'b000, '0, '0, 1, 3'b000, 1, 32'h22, 0, 1, 0);
    tv[5] = mk(3'b000, '0, '0, 1, 3'b000, 0, 0, 0, 0, 0);
    tv[6] = mk(3'b010, '0, {2'b00, 32'h55}, 1, 3'b010, 0, 0, 0, 0, 0);
    tv[7] = mk(3'b000, '0, '0, 1, 3'b000, 0, 0, 0, 0, 0);

    resetN    = 1'b0;
    req_valid = '1;
    req_data  = {NR{{2'b01, 32'hA5A5A5A5}}};
    out_ready = 1'b1;
    #12;
    chk("rst_ctl", 64'({out_valid, out_sop, out_eop, busy, err_abort}), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_grant", 64'(grant_id), 64'(0));
    chk("rst_pop", 64'(req_pop), 64'(0));
    @(posedge clk);
    #1;
    resetN = 1'b1;

    for (int r = 0; r < 8; r++) begin
      req_valid = tv[r].v;
      req_data  = {{WW{1'b0}}, tv[r].d1, tv[r].d0};
      out_ready = tv[r].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", r), 64'({req_pop, out_valid, busy}),
          64'({tv[r].pop, tv[r].ov, tv[r].b}));
      if (tv[r].ov)
        chk($sformatf("vec%0d_word", r), 64'({out_eop, out_sop, out_data}),
            64'({tv[r].e, tv[r].s, tv[r].od}));
      @(posedge clk);
      #1;
    end
    chk("single_grant", 64'(grant_id), 64'(0));
`ifdef ARB_STATS_EN
    chk("orph_drop_count", 64'(drop_count), 64'(1));
    chk("single_pkt_count", 64'(pkt_count), 64'(1));
`endif

    // back-pressure: ready high on odd cycles only
    rx.delete();
    use_q = 1;
    dq[0].push_back({2'b01, 32'hA0});
    dq[0].push_back({2'b00, 32'hA1});
    dq[0].push_back({2'b00, 32'hA2});
    dq[0].push_back({2'b10, 32'hA3});
    drive_q();
    left = 4;
    prev_pop = 0;
    for (int c = 0; c < 11; c++) begin
      out_ready = (c % 2 == 1);
      exp_pop = (c >= 1) && (left > 0) && out_ready;
      @(negedge clk);
      p = req_pop;
      chk($sformatf("bp_pop%0d", c), 64'(p), 64'({2'b00, exp_pop}));
      chk($sformatf("bp_ov%0d", c), 64'(out_valid), 64'(prev_pop));
      if (exp_pop) left--;
      prev_pop = exp_pop;
      @(posedge clk);
      #1;
      if (p[0] && dq[0].size() > 0) dq[0].delete(0);
      drive_q();
    end
    ex.delete();
    ex.push_back({2'b01, 32'hA0});
    ex.push_back({2'b00, 32'hA1});
    ex.push_back({2'b00, 32'hA2});
    ex.push_back({2'b10, 32'hA3});
    chk("bp_count", 64'(rx.size()), 64'(4));
    for (int i = 0; i < 4 && i < rx.size(); i++)
      chk($sformatf("bp_w%0d", i), 64'(rx[i]), 64'(ex[i]));

    // watchdog: 6 words without EOP, then a clean 2-word packet
    rx.delete();
    err_n = 0;
    err_eop_n = 0;
    out_ready = 1'b1;
    dq[0].push_back({2'b01, 32'hC0});
    for (int k = 1; k < 6; k++) dq[0].push_back({2'b00, 32'(32'hC0 + k)});
    dq[0].push_back({2'b01, 32'hD0});
    dq[0].push_back({2'b10, 32'hD1});
    drive_q();
    ex.delete();
    ex.push_back({2'b01, 32'hC0});
    ex.push_back({2'b00, 32'hC1});
    ex.push_back({2'b00, 32'hC2});
    ex.push_back({2'b10, 32'hC3});
    ex.push_back({2'b01, 32'hD0});
    ex.push_back({2'b10, 32'hD1});
    for (int c = 0; c < 60 && rx.size() < 6; c++) tick();
    chk("wd_count", 64'(rx.size()), 64'(6));
    for (int i = 0; i < 6 && i < rx.size(); i++)
      chk($sformatf("wd_w%0d", i), 64'(rx[i]), 64'(ex[i]));
    chk("wd_err", 64'(err_n), 64'(1));
    chk("wd_err_eop", 64'(err_eop_n), 64'(1));
    chk("wd_drained", 64'(dq[0].size()), 64'(0));
`ifdef ARB_STATS_EN
    chk("wd_pkt_count", 64'(pkt_count), 64'(4));
    chk("wd_drop_count", 64'(drop_count), 64'(3));
`endif

    // asynchronous reset in the middle of a packet
    add_pkt(0, 3, 0);
    tick();
    tick();
    #3;
    resetN = 1'b0;
    #1;
    chk("mid_rst_ctl", 64'({out_valid, out_sop, out_eop, busy, err_abort}), 64'(0));
    chk("mid_rst_data", 64'(out_data), 64'(0));
    chk("mid_rst_pop", 64'(req_pop), 64'(0));
    chk("mid_rst_grant", 64'(grant_id), 64'(0));
    for (int i = 0; i < NR; i++) begin
      dq[i].delete();
      mw[i].delete();
      ml[i].delete();
    end
    drive_q();
    @(posedge clk);
    #1;
    resetN = 1'b1;

    // contention: two requesters, two 3-word packets each
    rx.delete();
    gq.delete();
    for (int k = 0; k < 2; k++) begin
      add_pkt(0, 3, 0);
      add_pkt(1, 3, 0);
    end
    drive_q();
    model(NR - 1, rr_m);
    run_q("cont", 200);

    // randomized traffic with random back-pressure
    rnd_rdy = 1;
    for (int rnd = 0; rnd < 4; rnd++) begin
      rx.delete();
      gq.delete();
      e0 = err_n;
      for (int q = 0; q < NR; q++) begin
        int np;
        np = $urandom_range(0, 4);
        for (int k = 0; k < np; k++) add_pkt(q, $urandom_range(1, MX), 1);
      end
      drive_q();
      model(rr_m, rr_m);
      run_q($sformatf("rnd%0d", rnd), 3000);
      chk($sformatf("rnd%0d_noerr", rnd), 64'(err_n), 64'(e0));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
